// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite types, response codes, SRAM slave FSM states and byte-lane helper.
// Latency: n/a (declarations and a pure function only).
// Backpressure: n/a.
package ahb3lite_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'b000,
        HSIZE_HWORD = 3'b001,
        HSIZE_WORD  = 3'b010,
        HSIZE_DWORD = 3'b011
    } hsize_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } sram_state_t;

    // Little-endian byte-lane mask for one beat. Sizes wider than the bus are
    // clamped to the full bus and the lane offset is rounded down to the
    // transfer size, so an illegal beat still yields a well-formed mask.
    function automatic logic [7:0] lane_mask(input logic [2:0]  hsize,
                                             input logic [2:0]  addr_lsbs,
                                             input int unsigned bytes);
        int unsigned n;
        logic [2:0]  base;
        logic [7:0]  m;
        n = (hsize > 3'd3) ? 32'd8 : (32'd1 << hsize);
        if (n > bytes) begin
            n = bytes;
        end
        base = addr_lsbs & ~3'(n - 32'd1);
        m    = 8'((16'd1 << n) - 16'd1);
        return m << base;
    endfunction

endpackage

// File: rtl/ahb3lite_sram_array.sv
// Byte-enabled single-port-write / async-read storage array for the AHB SRAM slave.
// Latency: write commits on the clock edge with wr_en high; read is combinational.
// Backpressure: none, accepts a write every cycle.
module ahb3lite_sram_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic                     core_clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DATA_W/8-1:0]      wr_mask,
    input  logic [DATA_W-1:0]        wr_dat,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DATA_W-1:0]        rd_dat
);

    localparam int BYTES = DATA_W / 8;

    // Contents are never reset so that a bus reset leaves memory intact.
    logic [DATA_W-1:0] mem [DEPTH];

    // Masked byte-lane write.
    always_ff @(posedge core_clk) begin
        if (wr_en) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wr_mask[b]) begin
                    mem[wr_addr][8*b +: 8] <= wr_dat[8*b +: 8];
                end
            end
        end
    end

    assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/ahb3lite_sram_ws.sv
// AHB3-Lite SRAM slave with byte lanes, WAIT_STATES wait cycles per beat, optional ERROR (AHB3L_MEM_ERR_EN).
// Latency: OKAY data phase is WAIT_STATES+1 cycles; ERROR is two cycles; zero-wait beats pipeline one per cycle.
// Backpressure: HREADYOUT low during wait cycles and the first ERROR cycle; transfers are only taken while HREADY is high.
module ahb3lite_sram_ws
    import ahb3lite_pkg::*;
#(
    parameter int HADDR_SIZE  = 32,
    parameter int HDATA_SIZE  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    output logic [HDATA_SIZE-1:0] HRDATA,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP
);

    localparam int unsigned BYTES = HDATA_SIZE / 8;
    localparam int          LB    = $clog2(BYTES);
    localparam int          IW    = $clog2(MEM_DEPTH);

    sram_state_t           state, state_nxt;
    logic                  accept;
    logic                  illegal;
    logic [BYTES-1:0]      mask_d;
    logic [IW-1:0]         addr_q;
    logic                  write_q;
    hsize_t                size_q;
    logic [BYTES-1:0]      mask_q;
    logic [3:0]            wait_cnt;
    logic [HDATA_SIZE-1:0] rdata_q;
    logic [HDATA_SIZE-1:0] mem_rd;
    logic                  mem_we;
    logic                  unused_bits;

    // A new beat can only start while the slave is not stalling the bus.
    assign accept = HSEL && HREADY
                 && ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ))
                 && ((state == ST_IDLE) || (state == ST_DATA) || (state == ST_ERR2));

    assign mask_d = BYTES'(lane_mask(HSIZE, 3'(HADDR[LB-1:0]), BYTES));

`ifdef AHB3L_MEM_ERR_EN
    logic [LB-1:0] align_bits;
    logic          out_of_range;
    logic          size_big;
    logic          misaligned;

    assign align_bits   = LB'((32'd1 << HSIZE) - 32'd1);
    assign out_of_range = |HADDR[HADDR_SIZE-1:LB+IW];
    assign size_big     = (32'd1 << HSIZE) > BYTES;
    assign misaligned   = |(HADDR[LB-1:0] & align_bits);
    assign illegal      = out_of_range | size_big | misaligned;
    assign unused_bits  = ^{HBURST, HPROT, size_q};
`else
    // Upper address bits are dropped so the word index wraps modulo MEM_DEPTH.
    assign illegal      = 1'b0;
    assign unused_bits  = ^{HBURST, HPROT, size_q, HADDR[HADDR_SIZE-1:LB+IW]};
`endif

    // State register; reset abandons any beat in flight.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: DATA and ERR2 are the completing cycles and may take the next beat.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (!accept) begin
                    state_nxt = ST_IDLE;
                end else if (illegal) begin
                    state_nxt = ST_ERR1;
                end else if (WAIT_STATES > 0) begin
                    state_nxt = ST_WAIT;
                end else begin
                    state_nxt = ST_DATA;
                end
            end
            ST_WAIT: begin
                if (wait_cnt <= 4'd1) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_ERR1: state_nxt = ST_ERR2;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Bus handshake outputs decoded from the state.
    always_comb begin
        HREADYOUT = !((state == ST_WAIT) || (state == ST_ERR1));
`ifdef AHB3L_MEM_ERR_EN
        HRESP = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
`else
        HRESP = HRESP_OKAY;
`endif
    end

    // Address-phase capture, wait countdown and read-data hold register.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            addr_q   <= '0;
            write_q  <= 1'b0;
            size_q   <= HSIZE_BYTE;
            mask_q   <= '0;
            wait_cnt <= 4'd0;
            rdata_q  <= '0;
        end else begin
            if (accept) begin
                addr_q  <= HADDR[LB +: IW];
                write_q <= HWRITE;
                size_q  <= hsize_t'(HSIZE);
                mask_q  <= mask_d;
            end
            if (accept && !illegal && (WAIT_STATES > 0)) begin
                wait_cnt <= 4'(WAIT_STATES);
            end else if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (state == ST_DATA) begin
                rdata_q <= mem_rd;
            end
        end
    end

    // Commit on the edge closing DATA; a reset on that edge drops the write.
    assign mem_we = (state == ST_DATA) && write_q && !HRESET;

    assign HRDATA = (state == ST_DATA) ? mem_rd : rdata_q;

    ahb3lite_sram_array #(
        .DATA_W (HDATA_SIZE),
        .DEPTH  (MEM_DEPTH)
    ) u_array (
        .core_clk (HCLK),
        .wr_en    (mem_we),
        .wr_addr  (addr_q),
        .wr_mask  (mask_q),
        .wr_dat   (HWDATA),
        .rd_addr  (addr_q),
        .rd_dat   (mem_rd)
    );

endmodule
